// File: rtl/in_port_buffer.sv
// Input-port front end: valid/ready byte FIFO feeding the write-back mux with a one-cycle ie strobe.
// Optional IN_PORT_BYPASS_EN: a byte arriving while WAIT sees an empty FIFO goes straight to data_in.
module in_port_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       ext_data,
    input  logic                   ext_valid,
    output logic                   ext_ready,
    input  logic                   in_req,
    output logic                   in_busy,
    output logic [WIDTH-1:0]       data_in,
    output logic                   ie,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DELIVER} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             push_fifo;
    logic             pop;
    logic             bypass;

    // Extra wrap bit separates full from empty when the indices coincide.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count     = wr_ptr - rd_ptr;
    assign ext_ready = ~full;
    assign push      = ext_valid & ext_ready;
    assign in_busy   = (state != IDLE);

`ifdef IN_PORT_BYPASS_EN
    assign bypass = (state == WAIT) && empty && push;
`else
    assign bypass = 1'b0;
`endif

    assign push_fifo = push & ~bypass;
    assign pop       = ~empty && (((state == IDLE) && in_req) || (state == WAIT));

    // NOTE: storage is deliberately not reset; cleared pointers already mark every entry invalid.
    always_ff @(posedge clk) begin
        if (push_fifo) mem[wr_ptr[AW-1:0]] <= ext_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fifo) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: ie defaults low every cycle, so it can only ever be a single-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            data_in <= '0;
            ie      <= 1'b0;
        end else begin
            ie <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_req) begin
                        if (!empty) begin
                            data_in <= mem[rd_ptr[AW-1:0]];
                            ie      <= 1'b1;
                            state   <= DELIVER;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bypass) begin
                        data_in <= ext_data;
                        ie      <= 1'b1;
                        state   <= DELIVER;
                    end else if (!empty) begin
                        data_in <= mem[rd_ptr[AW-1:0]];
                        ie      <= 1'b1;
                        state   <= DELIVER;
                    end
                end
                DELIVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_in_port_buffer.sv
// Directed self-checking bench for in_port_buffer (DEPTH=4); honours IN_PORT_BYPASS_EN when defined.
module tb_in_port_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ext_data;
    logic       ext_valid;
    logic       ext_ready;
    logic       in_req;
    logic       in_busy;
    logic [7:0] data_in;
    logic       ie;
    logic [2:0] count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    in_port_buffer #(.DEPTH(4), .WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ext_data (ext_data),
        .ext_valid(ext_valid),
        .ext_ready(ext_ready),
        .in_req   (in_req),
        .in_busy  (in_busy),
        .data_in  (data_in),
        .ie       (ie),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        ext_data  = b;
        ext_valid = 1'b1;
        tick();
        ext_valid = 1'b0;
    endtask

    task automatic deliver(input string tag, input logic [7:0] exp, input logic [2:0] exp_count);
        in_req = 1'b1;
        tick();
        in_req = 1'b0;
        check({tag, "_ie"}, ie, 1);
        check({tag, "_data"}, data_in, exp);
        check({tag, "_count"}, count, exp_count);
        tick();
        check({tag, "_ie_drop"}, ie, 0);
    endtask

    initial begin
        rst_n = 1'b0; ext_data = 8'h00; ext_valid = 1'b0; in_req = 1'b0;
        #12;
        check("rst_data", data_in, 8'h00);
        check("rst_ie", ie, 0);
        check("rst_busy", in_busy, 0);
        check("rst_count", count, 0);
        check("rst_ready", ext_ready, 1);
        rst_n = 1'b1;
        tick();

        // Non-empty delivery
        push_byte(8'h11);
        push_byte(8'h22);
        check("ne_count2", count, 2);
        in_req = 1'b1;
        tick();
        in_req = 1'b0;
        check("ne_ie", ie, 1);
        check("ne_data", data_in, 8'h11);
        check("ne_busy", in_busy, 1);
        check("ne_count1", count, 1);
        tick();
        check("ne_ie_drop", ie, 0);
        check("ne_busy_drop", in_busy, 0);
        check("ne_hold", data_in, 8'h11);
        tick();
        check("ne_hold2", data_in, 8'h11);
        deliver("ne_drain", 8'h22, 0);

        // Reset mid-transfer
        push_byte(8'hA5);
        push_byte(8'h3C);
        in_req = 1'b1;
        tick();
        in_req = 1'b0;
        check("rm_ie_pre", ie, 1);
        check("rm_data_pre", data_in, 8'hA5);
        #2 rst_n = 1'b0;
        #1;
        check("rm_ie", ie, 0);
        check("rm_data", data_in, 8'h00);
        check("rm_count", count, 0);
        check("rm_busy", in_busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Empty wait (also proves no stale byte survives the reset)
        in_req = 1'b1;
        tick();
        in_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ew_busy", in_busy, 1);
            check("ew_ie", ie, 0);
            if (i < 2) tick();
        end
        ext_data  = 8'h7E;
        ext_valid = 1'b1;
        tick();
        ext_valid = 1'b0;
`ifdef IN_PORT_BYPASS_EN
        check("ew_byp_ie", ie, 1);
        check("ew_byp_data", data_in, 8'h7E);
        check("ew_byp_count", count, 0);
        tick();
        check("ew_byp_ie_drop", ie, 0);
        check("ew_byp_count2", count, 0);
`else
        check("ew_m_ie", ie, 0);
        check("ew_m_count", count, 1);
        tick();
        check("ew_ie", ie, 1);
        check("ew_data", data_in, 8'h7E);
        check("ew_count0", count, 0);
        tick();
        check("ew_ie_drop", ie, 0);
`endif
        check("ew_idle", in_busy, 0);

        // Full FIFO
        ext_valid = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            ext_data = 8'(b);
            tick();
        end
        check("ff_count4", count, 4);
        check("ff_ready0", ext_ready, 0);
        ext_data = 8'h05;
        tick();
        check("ff_no_accept", count, 4);
        in_req = 1'b1;
        tick();
        in_req = 1'b0;
        check("ff_ie", ie, 1);
        check("ff_data", data_in, 8'h01);
        check("ff_count3", count, 3);
        check("ff_ready1", ext_ready, 1);
        tick();
        ext_valid = 1'b0;
        check("ff_05_in", count, 4);
        deliver("ff_d2", 8'h02, 3);
        deliver("ff_d3", 8'h03, 2);
        deliver("ff_d4", 8'h04, 1);
        deliver("ff_d5", 8'h05, 0);

        // Pointer wrap
        for (int i = 0; i < 10; i++) begin
            push_byte(8'(i));
            check("pw_count1", count, 1);
            deliver("pw", 8'(i), 0);
        end

        // Ignored request during DELIVER
        push_byte(8'hAA);
        push_byte(8'hBB);
        in_req = 1'b1;
        tick();
        check("ir_ie", ie, 1);
        check("ir_data", data_in, 8'hAA);
        check("ir_count", count, 1);
        tick();
        in_req = 1'b0;
        check("ir_ie_drop", ie, 0);
        check("ir_busy", in_busy, 0);
        check("ir_count_hold", count, 1);
        tick();
        check("ir_no_second", ie, 0);
        check("ir_count_hold2", count, 1);
        check("ir_data_hold", data_in, 8'hAA);
        deliver("ir_drain", 8'hBB, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/in_port_buffer.md
# in_port_buffer

- Input-port front end for the 8-bit RISC datapath.
- Accepts bytes from an external device over a valid/ready handshake and queues them in a small FIFO.
- On an IN-instruction request from the control unit, delivers one byte on `data_in` with a one-cycle `ie` strobe.
- Sits directly upstream of the Bus_D/data_in write-back mux and drives both of that mux's `data_in` and `ie` inputs.

## Interface
- `DEPTH`, default 4: FIFO depth in bytes; power of two, minimum 2.
- `WIDTH`, default 8: data width; fixed at 8 in this design.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ext_data` input 8: byte offered by the external device.
- `ext_valid` input 1: `ext_data` is valid.
- `ext_ready` output 1: FIFO can accept a byte; equals `count != DEPTH`.
- `in_req` input 1: one-cycle pulse from the control unit requesting one input byte.
- `in_busy` output 1: request in progress, i.e. state is not IDLE; the control unit stalls on it.
- `data_in` output 8: delivered byte, registered, to the write-back mux.
- `ie` output 1: input enable, registered, high for exactly one cycle per delivered byte.
- `count` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO**
  - Circular buffer with `DEPTH` entries.
  - Read and write pointers each have one extra wrap bit: full when indices are equal and wrap bits differ; empty when pointers are equal.
  - Push occurs on `ext_valid & ext_ready`.
  - Pop occurs only on a delivery.
  - Simultaneous push and pop leaves `count` unchanged. When full, a pop frees a slot for the next cycle only; `ext_ready` does not look ahead.
- **FSM states: IDLE, WAIT, DELIVER**
  - IDLE, `in_req=1`, FIFO not empty: pop head into `data_in`, set `ie=1`, go to DELIVER.
  - IDLE, `in_req=1`, FIFO empty: go to WAIT.
  - WAIT, FIFO not empty: pop head into `data_in`, set `ie=1`, go to DELIVER.
  - DELIVER: clear `ie`, return to IDLE unconditionally.
- **Request handling**
  - `in_req` is sampled only in IDLE; pulses arriving in WAIT or DELIVER are dropped.
  - The control unit must not issue `in_req` while `in_busy=1`.
- **Data hold**
  - `data_in` keeps the last delivered byte until the next delivery.
  - `data_in` never changes while `ie=0` except at reset.
- **Reset**
  - Asserting `rst_n` mid-transfer aborts everything: pointers clear, FIFO contents are discarded, state returns to IDLE.
  - Reset values: `data_in=8'h00`, `ie=0`, `in_busy=0`, `count=0`, `ext_ready=1`.
  - Pushes are ignored while `rst_n=0`.

## Timing
- **Latency, FIFO non-empty:** `in_req` sampled at edge N; `ie=1` and the new `data_in` are visible in the cycle after N. `ie` drops after edge N+1.
- **`in_busy` for that request:** high in the cycle after N only.
- **Latency, FIFO empty (no bypass):**
  - Byte pushed at edge M while in WAIT.
  - `count` reads 1 after edge M.
  - Pop at edge M+1, with `ie=1` in the cycle after M+1.
- **Push/pop visibility:** a push at edge N is visible in `count` after N. It is poppable at the earliest at edge N+1, except via the bypass path.
- **Back-to-back deliveries:** one delivery per 2 cycles maximum, since DELIVER always returns to IDLE.
- **`ext_ready`:** combinational from `count`; no combinational path from `ext_valid` or `in_req` to any output.

## Configuration
- **Macro:** `IN_PORT_BYPASS_EN`.
- **Defined:**
  - Applies in WAIT when the FIFO is empty and `ext_valid & ext_ready` holds at edge M.
  - The byte is written straight to `data_in` at edge M with `ie=1`, and state goes to DELIVER.
  - The byte is not stored in the FIFO and `count` stays 0.
  - Result: `ie` is visible in the cycle after M, one cycle earlier than without bypass.
- **Undefined:** no bypass path; all bytes pass through the FIFO, with latency as stated in Timing.

## Test plan
- **Reset mid-transfer:**
  - Stimulus: push 8'hA5 and 8'h3C, then pulse `rst_n` low during DELIVER.
  - Required: `ie=0`, `data_in=8'h00`, `count=0`, `in_busy=0` immediately. No stale byte is delivered on the next `in_req`.
- **Non-empty delivery:**
  - Stimulus: push 8'h11, 8'h22, then `in_req` at edge N.
  - Required: `ie=1` and `data_in=8'h11` in the cycle after N only. `count` goes 2→1, and `data_in` stays 8'h11 afterwards.
- **Full FIFO (DEPTH=4):**
  - Stimulus: hold `ext_valid` with bytes 8'h01–8'h05.
  - Required: `ext_ready=0` after the 4th push and 8'h05 is not accepted. One `in_req` delivers 8'h01, after which `ext_ready=1` and 8'h05 enters.
- **Empty wait:**
  - Stimulus: `in_req` on an empty FIFO, `in_busy` checked for 3 cycles, then push 8'h7E at edge M.
  - Required without bypass: `ie` in the cycle after M+1 with `data_in=8'h7E`.
  - Required with `IN_PORT_BYPASS_EN`: `ie` in the cycle after M, with `count` staying 0.
- **Pointer wrap:**
  - Stimulus: 10 push/deliver pairs carrying bytes 8'h00–8'h09.
  - Required: delivered in order, `count` never exceeds 1, no byte lost or duplicated.
- **Ignored request:**
  - Stimulus: pulse `in_req` during DELIVER with 2 bytes queued.
  - Required: exactly one delivery, and `count` decrements by 1 only.
